fb_fill_ctrl: RTL
=================

Name: fb_fill_ctrl

Overview:
Write-side scheduler for the 800x600 8-bit framebuffer write port. It shares that single write port between two requesters:
- a point-write requester (CPU / sprite logic, one pixel per handshake);
- an internal rectangle-fill engine that sequences raster-order pixel writes for fill and clear commands.

It drives registered X/Y/colour plus a write-enable that gates the framebuffer write.

Parameters:
HSIZE, 800, visible width in pixels
VSIZE, 600, visible height in pixels
XW, 10, X coordinate width
YW, 10, Y coordinate width
CW, 8, colour width

Ports:
PIXEL_CLK  in  1  pixel clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
PT_REQ  in  1  point-write request; held high until PT_ACK
PT_X  in  XW  point X
PT_Y  in  YW  point Y
PT_COLOR  in  CW  point colour
PT_ACK  out  1  one-cycle ack; point write presented on outputs this cycle
RECT_START  in  1  one-cycle fill command strobe
RECT_X0  in  XW  left column, inclusive
RECT_Y0  in  YW  top row, inclusive
RECT_X1  in  XW  right column, inclusive
RECT_Y1  in  YW  bottom row, inclusive
RECT_COLOR  in  CW  fill colour
RECT_BUSY  out  1  high while a fill is in progress
RECT_DONE  out  1  one-cycle pulse at fill completion
PIX_HORIZONTAL  out  XW  write X to framebuffer
PIX_VERTICAL  out  YW  write Y to framebuffer
PIX_COLOR  out  CW  write colour to framebuffer
PIX_WE  out  1  write enable; framebuffer writes only when high

Behaviour:
- Reset: all outputs 0, FSM to IDLE, fill counters cleared. Reset mid-fill aborts the fill; no RECT_DONE is issued.
- FSM states:
  - IDLE: RECT_START captures corners and colour, goes to FILL and sets RECT_BUSY on the next cycle.
  - FILL: cursor starts at (X0,Y0); X increments to X1, then wraps to X0 and Y increments; after (X1,Y1) returns to IDLE.
  - RECT_START is ignored while in FILL.
- Empty rectangle (X0>X1 or Y0>Y1): no writes; RECT_DONE pulses one cycle after RECT_START; RECT_BUSY stays 0.
- Arbitration, decided each cycle n:
  - Point is granted if PT_REQ=1 and PT_ACK=0 in cycle n. This blocks a double grant of a held request.
  - Otherwise the fill is granted if in FILL.
  - Otherwise no grant.
  - Net effect: points win, but at most every other cycle. The fill gets the gap cycles and is never starved.
- Output timing:
  - Grant in cycle n puts X/Y/colour on the PIX_* outputs with PIX_WE=1 in cycle n+1 (one-cycle registered latency).
  - PT_ACK=1 in cycle n+1 for a point grant.
  - No grant: PIX_WE=0; PIX_* hold their previous values.
- Out-of-range point (PT_X>=HSIZE or PT_Y>=VSIZE): acknowledged normally, but PIX_WE=0 for that slot (dropped).
- The fill cursor advances only on a fill grant. A point grant stalls the cursor without losing position.
- RECT_DONE: asserted in the same cycle the final pixel (X1,Y1) appears with PIX_WE=1. RECT_BUSY drops in that same cycle.
- Simultaneous RECT_START and PT_REQ in IDLE: the point is granted, the command is still captured, and the fill starts on the following eligible slot.
- Width rules:
  - Counters are XW/YW bits with no arithmetic overflow; the X1/Y1 comparison uses equality.
  - X1=HSIZE-1 must terminate correctly. With the clip option disabled, X1 can reach 2^XW-1; the counter compares before incrementing, so it never wraps to 0 mid-row.

Optional Feature:
FILL_CLIP_EN
- Defined: at capture, X1/Y1 are clamped to HSIZE-1/VSIZE-1. A rectangle whose X0>=HSIZE or Y0>=VSIZE is treated as empty (RECT_DONE only).
- Undefined: corners are used unclamped. Cursor positions outside the screen consume a fill slot with PIX_WE=0. Completion timing counts every cursor position.

Test Plan:
- Reset then idle 10 cycles -> PIX_WE=0, PT_ACK=0, RECT_BUSY=0, RECT_DONE=0 throughout.
- Point write: PT_REQ held with (5,7,0xA3) -> exactly one PT_ACK, one cycle with PIX_WE=1 at (5,7,0xA3). A held PT_REQ with changed data gets its next ack no earlier than 2 cycles later.
- Fill (2,3)-(4,4) colour 0x1F, no points -> 6 writes in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on consecutive cycles. RECT_DONE coincides with (4,4); RECT_BUSY is high for 6 cycles.
- Fill (0,0)-(9,0) with PT_REQ held continuously -> writes alternate point/fill. All 10 fill pixels are written exactly once, in order, and RECT_DONE arrives within 21 cycles.
- Empty rectangle X0=10, X1=3 -> no PIX_WE; RECT_DONE pulse 1 cycle after RECT_START. Point (800,0) -> acked with PIX_WE=0.
- RST asserted after 3 pixels of a 20-pixel fill -> outputs 0 next cycle and no RECT_DONE. A new fill after reset completes normally. With FILL_CLIP_EN defined, fill (798,599)-(1023,1023) writes only (798,599) and (799,599).

Source files
------------

// File: rtl/fb_fill_ctrl.sv
// fb_fill_ctrl: write-side scheduler for the 800x600 8-bit framebuffer port.
// Shares one write port between a point-write requester and a raster-order
// rectangle-fill engine. Points win arbitration but at most every other
// cycle, so the fill always gets the gap cycles.
// Optional build macro: FILL_CLIP_EN clamps fill corners to the visible area
// at capture time and treats fully off-screen rectangles as empty.
//
// Handshake: PT_REQ is held high with stable data until the cycle PT_ACK is
// seen high; PT_ACK is a one-cycle pulse coinciding with that point's slot
// on the PIX_* outputs (PIX_WE low if the point was off-screen).
module fb_fill_ctrl #(
  parameter int HSIZE = 800,
  parameter int VSIZE = 600,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int CW    = 8
) (
  input  logic          PIXEL_CLK,
  input  logic          RST,
  input  logic          PT_REQ,
  input  logic [XW-1:0] PT_X,
  input  logic [YW-1:0] PT_Y,
  input  logic [CW-1:0] PT_COLOR,
  output logic          PT_ACK,
  input  logic          RECT_START,
  input  logic [XW-1:0] RECT_X0,
  input  logic [YW-1:0] RECT_Y0,
  input  logic [XW-1:0] RECT_X1,
  input  logic [YW-1:0] RECT_Y1,
  input  logic [CW-1:0] RECT_COLOR,
  output logic          RECT_BUSY,
  output logic          RECT_DONE,
  output logic [XW-1:0] PIX_HORIZONTAL,
  output logic [YW-1:0] PIX_VERTICAL,
  output logic [CW-1:0] PIX_COLOR,
  output logic          PIX_WE
);

  localparam logic [XW-1:0] LP_XMAX = XW'(HSIZE - 1);
  localparam logic [YW-1:0] LP_YMAX = YW'(VSIZE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [XW-1:0] r_x0;
  logic [XW-1:0] r_x1;
  logic [YW-1:0] r_y1;
  logic [CW-1:0] r_fill_color;
  logic [XW-1:0] r_cur_x;
  logic [YW-1:0] r_cur_y;

  logic          r_pt_ack;
  logic          r_done;
  logic          r_we;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic [CW-1:0] r_pix_color;

  logic [XW-1:0] w_cap_x1;
  logic [YW-1:0] w_cap_y1;
  logic          w_cap_empty;
  logic          w_start_ok;
  logic          w_start_fill;
  logic          w_pt_grant;
  logic          w_fill_grant;
  logic          w_row_end;
  logic          w_last;
  logic          w_pt_on_screen;
  logic          w_cur_on_screen;
  logic          w_busy;

`ifdef FILL_CLIP_EN
  // Clamp the far corner to the screen; off-screen origins become empty fills
  always_comb begin
    w_cap_x1    = (RECT_X1 > LP_XMAX) ? LP_XMAX : RECT_X1;
    w_cap_y1    = (RECT_Y1 > LP_YMAX) ? LP_YMAX : RECT_Y1;
    w_cap_empty = (RECT_X0 > LP_XMAX) || (RECT_Y0 > LP_YMAX) ||
                  (RECT_X0 > w_cap_x1) || (RECT_Y0 > w_cap_y1);
  end
`else
  // Corners are used as given; off-screen cursor positions still take a slot
  always_comb begin
    w_cap_x1    = RECT_X1;
    w_cap_y1    = RECT_Y1;
    w_cap_empty = (RECT_X0 > RECT_X1) || (RECT_Y0 > RECT_Y1);
  end
`endif

  // Arbitration and cursor decode; r_pt_ack blocks a second grant of a held request
  always_comb begin
    w_start_ok      = (r_state == S_IDLE) && RECT_START;
    w_start_fill    = w_start_ok && !w_cap_empty;
    w_pt_grant      = PT_REQ && !r_pt_ack;
    w_fill_grant    = !w_pt_grant && (r_state == S_FILL);
    w_row_end       = (r_cur_x == r_x1);
    w_last          = w_row_end && (r_cur_y == r_y1);
    w_pt_on_screen  = (PT_X <= LP_XMAX) && (PT_Y <= LP_YMAX);
    w_cur_on_screen = (r_cur_x <= LP_XMAX) && (r_cur_y <= LP_YMAX);
  end

  // FSM state register
  always_ff @(posedge PIXEL_CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next state: leave FILL only when the final cursor position is granted
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_start_fill) w_next_state = S_FILL;
      S_FILL: if (w_fill_grant && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers exactly the cycles a fill slot can be granted
  always_comb begin
    w_busy = (r_state == S_FILL);
  end

  // Fill command capture and cursor walk (equality compares, never wraps)
  always_ff @(posedge PIXEL_CLK) begin
    if (RST) begin
      r_x0         <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_fill_color <= '0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
    end else if (w_start_fill) begin
      r_x0         <= RECT_X0;
      r_x1         <= w_cap_x1;
      r_y1         <= w_cap_y1;
      r_fill_color <= RECT_COLOR;
      r_cur_x      <= RECT_X0;
      r_cur_y      <= RECT_Y0;
    end else if (w_fill_grant && !w_last) begin
      if (w_row_end) begin
        r_cur_x <= r_x0;
        r_cur_y <= r_cur_y + YW'(1);
      end else begin
        r_cur_x <= r_cur_x + XW'(1);
      end
    end
  end

  // Registered write port: one-cycle latency from grant to PIX_* / PT_ACK
  always_ff @(posedge PIXEL_CLK) begin
    if (RST) begin
      r_pt_ack    <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
    end else begin
      r_pt_ack <= w_pt_grant;
      r_done   <= (w_fill_grant && w_last) || (w_start_ok && w_cap_empty);
      if (w_pt_grant) begin
        r_we <= w_pt_on_screen;
        if (w_pt_on_screen) begin
          r_pix_x     <= PT_X;
          r_pix_y     <= PT_Y;
          r_pix_color <= PT_COLOR;
        end
      end else if (w_fill_grant) begin
        r_we <= w_cur_on_screen;
        if (w_cur_on_screen) begin
          r_pix_x     <= r_cur_x;
          r_pix_y     <= r_cur_y;
          r_pix_color <= r_fill_color;
        end
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign PT_ACK         = r_pt_ack;
  assign RECT_BUSY      = w_busy;
  assign RECT_DONE      = r_done;
  assign PIX_WE         = r_we;
  assign PIX_HORIZONTAL = r_pix_x;
  assign PIX_VERTICAL   = r_pix_y;
  assign PIX_COLOR      = r_pix_color;

endmodule
